// File: rtl/mcycle_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface mcycle_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, InstrDone, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, InstrDone, Illegal
  );
endinterface

// File: rtl/mcycle_controller.sv
// Moore FSM sequencing a shared-memory multicycle RV32I datapath, with a
// memory-ready handshake, optional bus timeout and a sticky FAULT state.
module mcycle_controller #(
  parameter int MEM_TIMEOUT = 0,
  parameter bit ENABLE_BNE  = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  mcycle_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JAL     = 4'd10;
  localparam logic [3:0] S_FAULT   = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       alu_op;
  logic             wait_state, timeout_hit;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;

  function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic op5, input logic f7b5);
    logic [2:0] ctl;
    ctl = 3'b000;
    case (aop)
      2'b00: ctl = 3'b000;
      2'b01: ctl = 3'b001;
      default: begin
        case (f3)
          3'b000:  ctl = (op5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  ctl = 3'b101;
          3'b110:  ctl = 3'b011;
          3'b111:  ctl = 3'b010;
          default: ctl = 3'b000;
        endcase
      end
    endcase
    return ctl;
  endfunction

  // Only the three memory-facing states can stall on MemReady.
  assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWR);
  assign timeout_hit = (MEM_TIMEOUT > 0) && wait_state && !bus.MemReady &&
                       ((int'(cnt_q) + 1) >= MEM_TIMEOUT);

  always_comb begin
    cnt_d = '0;
    if ((MEM_TIMEOUT > 0) && wait_state && !bus.MemReady && !timeout_hit)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    case (bus.op)
      OP_LW, OP_I: imm_src = 2'b00;
      OP_SW:       imm_src = 2'b01;
      OP_BR:       imm_src = 2'b10;
      OP_JAL:      imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = ((bus.funct3 == 3'b000) ||
                                   ((bus.funct3 == 3'b001) && ENABLE_BNE)) ? S_BRANCH : S_FAULT;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = bus.MemReady;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        pc_write   = bus.Zero ^ (bus.funct3 == 3'b001);
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: illegal = 1'b1;
      default: state_d = S_FAULT;
    endcase
    if (timeout_hit) state_d = S_FAULT;
    // Reset overrides the decode so nothing is written while it is held.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b10;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      alu_op     = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUControl = alu_decode(alu_op, bus.funct3, bus.op[5], bus.funct7b5);
  assign bus.InstrDone  = instr_done;
  assign bus.Illegal    = illegal;

endmodule

// File: tb/tb_mcycle_controller.sv
// Bench for mcycle_controller: an instruction-step reference model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_mcycle_controller;

  localparam int TO = 4;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_BAD = 6;

  logic clk;
  logic reset;
  mcycle_if bus ();

  mcycle_controller #(.MEM_TIMEOUT(TO), .ENABLE_BNE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  chk_total = 0;
  int  chk_pass  = 0;
  bit  run       = 1'b0;

  // Reference model: which step (1 = fetch) of which instruction class we are in.
  int m_step = 1, m_cls = C_BAD, m_wait = 0;
  bit m_fault = 1'b0;
  int n_step, n_cls, n_wait;
  bit n_fault;

  function automatic int classify(input logic [6:0] o, input logic [2:0] f);
    if (o == 7'b0000011) return C_LW;
    if (o == 7'b0100011) return C_SW;
    if (o == 7'b0110011) return C_R;
    if (o == 7'b0010011) return C_I;
    if (o == 7'b1101111) return C_JAL;
    if (o == 7'b1100011 && (f == 3'd0 || f == 3'd1)) return C_BR;
    return C_BAD;
  endfunction

  function automatic int last_step(input int c);
    if (c == C_LW) return 5;
    if (c == C_SW || c == C_R || c == C_I) return 4;
    return 3;
  endfunction

  function automatic bit waits_on_mem(input int s, input int c);
    return (s == 1) || (s == 4 && (c == C_LW || c == C_SW));
  endfunction

  function automatic logic [2:0] alu_r(input logic [6:0] o, input logic [2:0] f, input logic f7);
    if (f == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
    if (f == 3'd2) return 3'd5;
    if (f == 3'd6) return 3'd3;
    if (f == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [17:0] expected();
    logic pcw, adr, mw, irw, rw, done, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
    res = 0; sa = 0; sb = 0; alu = 0;
    if (reset) begin
      res = 2'b10; sb = 2'b10;
    end else if (m_fault) begin
      ill = 1;
    end else if (m_step == 1) begin
      sb = 2'b10; res = 2'b10; pcw = bus.MemReady; irw = bus.MemReady;
    end else if (m_step == 2) begin
      sa = 2'b01; sb = 2'b01;
    end else if (m_step == 3) begin
      if (m_cls == C_LW || m_cls == C_SW) begin sa = 2'b10; sb = 2'b01; end
      else if (m_cls == C_R) begin sa = 2'b10; alu = alu_r(bus.op, bus.funct3, bus.funct7b5); end
      else if (m_cls == C_I) begin sa = 2'b10; sb = 2'b01; alu = alu_r(bus.op, bus.funct3, bus.funct7b5); end
      else if (m_cls == C_BR) begin sa = 2'b10; alu = 3'd1; done = 1; pcw = bus.Zero ^ (bus.funct3 == 3'd1); end
      else begin sa = 2'b01; sb = 2'b10; pcw = 1; done = 1; end
    end else if (m_step == 4) begin
      if (m_cls == C_LW) adr = 1;
      else if (m_cls == C_SW) begin adr = 1; mw = 1; done = bus.MemReady; end
      else begin rw = 1; done = 1; end
    end else begin
      res = 2'b01; rw = 1; done = 1;
    end
    return {pcw, adr, mw, irw, res, sa, sb, imm_of(bus.op), rw, alu, done, ill};
  endfunction

  always_comb begin
    n_step = m_step; n_cls = m_cls; n_wait = m_wait; n_fault = m_fault;
    if (reset) begin
      n_step = 1; n_wait = 0; n_fault = 0;
    end else if (!m_fault) begin
      if (waits_on_mem(m_step, m_cls)) begin
        if (bus.MemReady) begin
          n_wait = 0;
          n_step = (m_step == last_step(m_cls)) ? 1 : m_step + 1;
        end else begin
          n_wait = m_wait + 1;
          if (n_wait == TO) begin n_fault = 1; n_wait = 0; end
        end
      end else if (m_step == 2) begin
        n_cls = classify(bus.op, bus.funct3);
        if (n_cls == C_BAD) n_fault = 1; else n_step = 3;
      end else begin
        n_step = (m_step == last_step(m_cls)) ? 1 : m_step + 1;
      end
    end
  end

  always @(posedge clk) begin
    m_step  <= n_step;
    m_cls   <= n_cls;
    m_wait  <= n_wait;
    m_fault <= n_fault;
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [17:0] act, exp_v;
    forever begin
      @(negedge clk);
      if (run) begin
        act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
               bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl,
               bus.InstrDone, bus.Illegal};
        exp_v = expected();
        chk_total++;
        if (act === exp_v) chk_pass++;
        else $display("FAIL model_cycle t=%0t step=%0d cls=%0d got=%b want=%b",
                      $time, m_step, m_cls, act, exp_v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp_v);
    chk_total++;
    if (act == exp_v) chk_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
  endtask

  logic       o_pcw, o_irw, o_mw, o_rw, o_done, o_ill;
  logic [1:0] o_res, o_imm, o_sb;
  logic [2:0] o_alu;

  task automatic cyc(input logic mr, input logic z);
    bus.MemReady = mr;
    bus.Zero     = z;
    #1;
    o_pcw = bus.PCWrite;   o_irw = bus.IRWrite;  o_mw  = bus.MemWrite;
    o_rw  = bus.RegWrite;  o_done = bus.InstrDone; o_ill = bus.Illegal;
    o_res = bus.ResultSrc; o_imm = bus.ImmSrc;   o_alu = bus.ALUControl;
    o_sb  = bus.ALUSrcB;
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic f7);
    bus.op = o; bus.funct3 = f; bus.funct7b5 = f7;
  endtask

  int c1_irw, c3_pcw, c3_imm, c3_alu, n_done;

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input logic z, input int n);
    set_instr(o, f, f7);
    n_done = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(1'b1, z);
      n_done += int'(o_done);
      if (i == 1) c1_irw = int'(o_irw);
      if (i == 3) begin c3_pcw = int'(o_pcw); c3_imm = int'(o_imm); c3_alu = int'(o_alu); end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c, last_done;
    reset = 1'b1;
    set_instr(7'b0000011, 3'b010, 1'b0);
    bus.MemReady = 1'b1;
    bus.Zero = 1'b0;
    run = 1'b1;
    cyc(1'b1, 1'b0);
    check("rst_resultsrc", int'(o_res), 2);
    check("rst_alusrcb", int'(o_sb), 2);
    check("rst_enables", int'({o_pcw, o_irw, o_mw, o_rw, o_done, o_ill}), 0);
    cyc(1'b1, 1'b0);
    reset = 1'b0;

    // lw: five cycles, writeback only in the last
    set_instr(7'b0000011, 3'b010, 1'b0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0);
      cnt_a += int'(o_done);
      if (o_rw) begin cnt_b++; cnt_c = i; end
      if (i == 5) check("lw_resultsrc_c5", int'(o_res), 1);
    end
    check("lw_done_pulses", cnt_a, 1);
    check("lw_regwrite_cycles", cnt_b, 1);
    check("lw_regwrite_at", cnt_c, 5);

    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4);
    check("fetch_after_lw", c1_irw, 1);
    check("sub_aluctl", c3_alu, 1);
    check("r_done_pulses", n_done, 1);
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4);
    check("add_aluctl", c3_alu, 0);
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 4);
    check("and_aluctl", c3_alu, 2);
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 4);
    check("slt_aluctl", c3_alu, 5);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 4);
    check("addi_f7_aluctl", c3_alu, 0);
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 4);
    check("ori_aluctl", c3_alu, 3);

    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 3);
    check("bne_z0_pcw", c3_pcw, 1);
    check("bne_immsrc", c3_imm, 2);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 3);
    check("bne_z1_pcw", c3_pcw, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3);
    check("beq_z0_pcw", c3_pcw, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3);
    check("beq_z1_pcw", c3_pcw, 1);
    check("beq_immsrc", c3_imm, 2);
    check("beq_done_pulses", n_done, 1);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 3);
    check("jal_pcw", c3_pcw, 1);
    check("jal_immsrc", c3_imm, 3);

    // Fetch stalled three cycles, then an R-type add completes
    set_instr(7'b0110011, 3'b000, 1'b0);
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      cnt_a += int'(o_irw) + int'(o_pcw);
    end
    check("stall_no_enables", cnt_a, 0);
    cyc(1'b1, 1'b0);
    check("stall_irw_pulse", int'(o_irw), 1);
    check("stall_pcw_pulse", int'(o_pcw), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);

    // sw with MemReady low for two write cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    check("sw_immsrc", int'(o_imm), 1);
    cnt_a = 0; cnt_b = 0; last_done = 0;
    for (int i = 0; i < 3; i++) begin
      cyc((i == 2) ? 1'b1 : 1'b0, 1'b0);
      cnt_a += int'(o_mw);
      cnt_b += int'(o_done);
      last_done = int'(o_done);
    end
    check("sw_memwrite_cycles", cnt_a, 3);
    check("sw_done_pulses", cnt_b, 1);
    check("sw_done_last", last_done, 1);

    // Illegal opcode lands in FAULT and stays there
    set_instr(7'b1110011, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("ill_decode_clear", int'(o_ill), 0);
    cyc(1'b1, 1'b0);
    check("ill_set", int'(o_ill), 1);
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      cnt_a += int'(o_pcw) + int'(o_irw) + int'(o_mw) + int'(o_rw) + int'(o_done);
    end
    check("ill_no_enables", cnt_a, 0);
    check("ill_sticky", int'(o_ill), 1);
    pulse_reset();

    // lw with the read never completing: timeout into FAULT
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(1'b1, 1'b0);
    check("reset_clears_ill", int'(o_ill), 0);
    check("reset_fetch_irw", int'(o_irw), 1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      cnt_a += int'(o_ill) + int'(o_done);
    end
    check("to_wait_quiet", cnt_a, 0);
    cyc(1'b1, 1'b0);
    check("to_fault", int'(o_ill), 1);
    pulse_reset();

    // Same, but ready arrives on the fourth waiting cycle
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("to_ready_wins_rw", int'(o_rw), 1);
    check("to_ready_wins_ill", int'(o_ill), 0);
    check("to_ready_wins_res", int'(o_res), 1);
    cyc(1'b1, 1'b0);
    check("to_back_fetch", int'(o_irw), 1);

    run = 1'b0;
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
